alu_seq: RTL and testbench

Parametrised, handshaked ALU for the datapath. It accepts one operation per transfer on a valid/ready input port and returns a registered result with status flags on a valid/ready output port. Logic, shift, rotate, add, subtract and compare complete in one cycle. Multiply (full double-width product) and divide (quotient and remainder) run as iterative multi-cycle operations. It replaces the fixed 8-bit, flag-less ALU in new designs.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/shift/add/compare ops plus iterative
// shift-add multiply and restoring divide, with registered result and flags.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_dz
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_reg, state_next;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] acc_hi_reg;   // MUL: product high half, DIV: partial remainder
  logic [WIDTH-1:0] acc_lo_reg;   // MUL: multiplier/product low half, DIV: dividend/quotient
  logic [WIDTH-1:0] opnd_reg;     // MUL: multiplicand, DIV: divisor

  logic             accept;
  logic             last;

  assign in_ready = (state_reg == S_IDLE) && (!out_valid || out_ready) && !rst;
  assign accept   = in_valid && in_ready;
  assign last     = (cnt_reg == SHW'(WIDTH - 1));

  // Single-cycle datapath
  logic [SHW-1:0]   sh, rot_amt, rot_neg;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0] rot_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;

  assign sh      = b[SHW-1:0];
  assign add_w   = {1'b0, a} + {1'b0, b};
  assign sub_w   = {1'b0, a} - {1'b0, b};
  assign shl_w   = {1'b0, a} << sh;
  assign shr_w   = {a, 1'b0} >> sh;
  // ROR is a ROL by the negated amount; a zero amount ORs a with itself.
  assign rot_amt = (op == OP_ROR) ? (~sh + 1'b1) : sh;
  assign rot_neg = ~rot_amt + 1'b1;
  assign rot_res = (a << rot_amt) | (a >> rot_neg);

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[MSB:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_w[MSB:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_SHL: begin
        sc_res = shl_w[MSB:0];
        sc_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        sc_c   = shr_w[0];
      end
      OP_ROL, OP_ROR: sc_res = rot_res;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NAND: sc_res = ~(a & b);
      OP_NOR:  sc_res = ~(a | b);
      OP_XNOR: sc_res = ~(a ^ b);
      OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
      default: sc_res = '0;
    endcase
  end

  // One multiply step: conditionally add multiplicand, then shift product right.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;

  assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], acc_lo_reg[MSB:1]};

  // One restoring-divide step; a zero divisor naturally yields all-ones and rem = a.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_next, quo_next;

  assign div_shift = {acc_hi_reg, acc_lo_reg[MSB]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign rem_next  = div_ge ? div_diff[MSB:0] : div_shift[MSB:0];
  assign quo_next  = {acc_lo_reg[MSB-1:0], div_ge};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept && op == OP_MUL)      state_next = S_MUL;
        else if (accept && op == OP_DIV) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
      flag_dz    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        if (op == OP_MUL) begin
          acc_hi_reg <= '0;
          acc_lo_reg <= b;
          opnd_reg   <= a;
          cnt_reg    <= '0;
        end else if (op == OP_DIV) begin
          acc_hi_reg <= '0;
          acc_lo_reg <= a;
          opnd_reg   <= b;
          cnt_reg    <= '0;
        end else begin
          out_valid <= 1'b1;
          result    <= sc_res;
          result_hi <= '0;
          flag_c    <= sc_c;
          flag_v    <= sc_v;
          flag_z    <= (sc_res == '0);
          flag_n    <= sc_res[MSB];
          flag_dz   <= 1'b0;
        end
      end else if (state_reg == S_MUL) begin
        acc_hi_reg <= mul_hi_next;
        acc_lo_reg <= mul_lo_next;
        cnt_reg    <= cnt_reg + 1'b1;
        if (last) begin
          out_valid <= 1'b1;
          result    <= mul_lo_next;
          result_hi <= mul_hi_next;
          flag_c    <= 1'b0;
          flag_v    <= 1'b0;
          flag_z    <= (mul_lo_next == '0);
          flag_n    <= mul_lo_next[MSB];
          flag_dz   <= 1'b0;
        end
      end else if (state_reg == S_DIV) begin
        acc_hi_reg <= rem_next;
        acc_lo_reg <= quo_next;
        cnt_reg    <= cnt_reg + 1'b1;
        if (last) begin
          out_valid <= 1'b1;
          result    <= quo_next;
          result_hi <= rem_next;
          flag_c    <= 1'b0;
          flag_v    <= 1'b0;
          flag_z    <= (quo_next == '0);
          flag_n    <= quo_next[MSB];
          flag_dz   <= (opnd_reg == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH 8/16/32 sharing one stimulus bus;
// the instance selected by sel is the one being observed.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  fl;   // {c, z, v, n, dz}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b;

  logic        ir8, ov8, ir16, ov16, ir32, ov32;
  logic [7:0]  r8, h8;
  logic [15:0] r16, h16;
  logic [31:0] r32, h32;
  logic [4:0]  f8, f16, f32;

  int          sel;
  logic        o_rdy, o_val;
  logic [31:0] o_res, o_hi;
  logic [4:0]  o_fl;

  int          checks = 0;
  int          errors = 0;
  int          npop   = 0;
  exp_t        q[$];
  exp_t        e_mon;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(r8), .result_hi(h8), .flag_c(f8[4]), .flag_z(f8[3]),
    .flag_v(f8[2]), .flag_n(f8[1]), .flag_dz(f8[0]));

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .op(op),
    .a(a[15:0]), .b(b[15:0]), .out_valid(ov16), .out_ready(out_ready),
    .result(r16), .result_hi(h16), .flag_c(f16[4]), .flag_z(f16[3]),
    .flag_v(f16[2]), .flag_n(f16[1]), .flag_dz(f16[0]));

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .op(op),
    .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .result_hi(h32), .flag_c(f32[4]), .flag_z(f32[3]),
    .flag_v(f32[2]), .flag_n(f32[1]), .flag_dz(f32[0]));

  always_comb begin
    o_rdy = ir8; o_val = ov8; o_res = {24'b0, r8}; o_hi = {24'b0, h8}; o_fl = f8;
    case (sel)
      1: begin o_rdy = ir16; o_val = ov16; o_res = {16'b0, r16}; o_hi = {16'b0, h16}; o_fl = f16; end
      2: begin o_rdy = ir32; o_val = ov32; o_res = r32; o_hi = h32; o_fl = f32; end
      default: ;
    endcase
  end

  // Reference model, written directly from the opcode definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] ai, input logic [31:0] bi, input int w);
    logic [63:0] m, x, y, p, hi;
    logic        c, v, dz;
    int          s;
    exp_t        e;
    m  = (64'd1 << w) - 64'd1;
    x  = {32'b0, ai} & m;
    y  = {32'b0, bi} & m;
    s  = int'(y % 64'(w));
    p  = 64'd0; hi = 64'd0; c = 1'b0; v = 1'b0; dz = 1'b0;
    case (o)
      4'd0: begin p = x + y; c = p[w]; v = (x[w-1] == y[w-1]) && (p[w-1] != x[w-1]); end
      4'd1: begin p = (x - y) & m; c = (x < y); v = (x[w-1] != y[w-1]) && (p[w-1] != x[w-1]); end
      4'd2: begin p = x * y; hi = (p >> w) & m; end
      4'd3: begin
        if (y == 64'd0) begin p = m; hi = x; dz = 1'b1; end
        else begin p = x / y; hi = x % y; end
      end
      4'd4: begin p = x << s; if (s != 0) c = p[w]; end
      4'd5: begin p = x >> s; if (s != 0) c = x[s-1]; end
      4'd6: p = (x << s) | (x >> (w - s));
      4'd7: p = (x >> s) | (x << (w - s));
      4'd8:  p = x & y;
      4'd9:  p = x | y;
      4'd10: p = x ^ y;
      4'd11: p = ~(x & y);
      4'd12: p = ~(x | y);
      4'd13: p = ~(x ^ y);
      4'd14: p = (x > y) ? 64'd1 : 64'd0;
      default: p = (x == y) ? 64'd1 : 64'd0;
    endcase
    p = p & m;
    e.res = p[31:0];
    e.hi  = hi[31:0];
    e.fl  = {c, (p == 64'd0), v, p[w-1], dz};
    return e;
  endfunction

  // Output monitor: every output transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && o_val && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_result w=%0d res=%h hi=%h fl=%b", 8 << sel, o_res, o_hi, o_fl);
      end else begin
        e_mon = q.pop_front();
        npop++;
        assert ({o_res, o_hi, o_fl} === {e_mon.res, e_mon.hi, e_mon.fl}) else begin
          errors++;
          $error("FAIL result w=%0d got res=%h hi=%h fl=%b want res=%h hi=%h fl=%b",
                 8 << sel, o_res, o_hi, o_fl, e_mon.res, e_mon.hi, e_mon.fl);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  // Present one op, hold until accepted; waits = cycles spent (1 = immediate).
  task automatic send(input logic [3:0] o, input logic [31:0] ai, input logic [31:0] bi, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    op = o; a = ai; b = bi; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = o_rdy;
      if (acc) q.push_back(model(o, ai, bi, 8 << sel));
      @(posedge clk); #1;
      waits++;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [3:0]  d_op[15] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd14, 4'd15, 4'd2};
  logic [31:0] d_a[15]  = '{32'hFF, 32'h7F, 32'h03, 32'h80, 32'd200, 32'd9, 32'h81, 32'h81, 32'h81, 32'h81, 32'h01, 32'h0F, 32'd5, 32'd4, 32'd13};
  logic [31:0] d_b[15]  = '{32'h01, 32'h01, 32'h05, 32'h01, 32'd7, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd3, 32'hF0, 32'd3, 32'd4, 32'd11};

  initial begin
    int wt, lat, p0;
    logic [3:0] ro;
    sel = 0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, o_val}, 32'd0);
    chk("rst_result", o_res, 32'd0);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_flags", {27'b0, o_fl}, 32'd0);
    chk("rst_in_ready", {31'b0, o_rdy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, o_rdy}, 32'd1);

    send(4'd0, 32'h12, 32'h34, wt);
    drain();

    // Reset in the middle of a divide
    send(4'd3, 32'd200, 32'd7, wt);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    chk("middiv_valid", {31'b0, o_val}, 32'd0);
    chk("middiv_result", o_res, 32'd0);
    chk("middiv_hi", o_hi, 32'd0);
    chk("middiv_flags", {27'b0, o_fl}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("middiv_ready", {31'b0, o_rdy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("middiv_no_result", {31'b0, o_val}, 32'd0);
      @(posedge clk); #1;
    end
    send(4'd0, 32'd1, 32'd1, wt);
    drain();

    // Directed vectors: flags, iterative ops, shifts, rotates, compares
    for (int i = 0; i < 15; i++) begin
      send(d_op[i], d_a[i], d_b[i], wt);
      drain();
    end

    // MUL latency and in_ready while busy
    send(4'd2, 32'hFF, 32'hFF, wt);
    lat = 0;
    while (!o_val && lat < 40) begin
      chk("mul_busy_in_ready", {31'b0, o_rdy}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", lat, 32'd8);
    drain();

    // Backpressure, then simultaneous transfer and acceptance
    out_ready = 1'b0;
    send(4'd0, 32'h12, 32'h34, wt);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, o_val}, 32'd1);
      chk("bp_result", o_res, 32'h46);
      chk("bp_in_ready", {31'b0, o_rdy}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(4'd10, 32'h0F, 32'h3C, wt);
    chk("bp_same_cycle_accept", wt, 32'd1);
    chk("bp_next_valid", {31'b0, o_val}, 32'd1);
    drain();

    // Streaming at each width
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      p0 = npop;
      for (int i = 0; i < 16; i++) begin
        ro = 4'($urandom_range(0, 13));
        if (ro >= 4'd2) ro = ro + 4'd2;
        send(ro, $urandom, $urandom, wt);
        chk("stream_back_to_back", wt, 32'd1);
        if (i > 0) chk("stream_valid", {31'b0, o_val}, 32'd1);
      end
      drain();
      chk("stream_count", npop - p0, 32'd16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
